// File: rtl/bus_arbiter_if.sv
// Request/response and memory-bus signal bundle for bus_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface bus_arbiter_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [N-1:0]        req_read;
  logic [N-1:0]        req_write;
  logic [N-1:0]        req_lock;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        grant;
  logic [N-1:0]        done;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data_out;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [DATA_W-1:0]   mem_data_in;
  logic                mem_read_dn;
  logic                mem_write_dn;
  logic                is_bus_busy;
  logic                err;

  modport slave (
    input  req_read, req_write, req_lock, req_addr, req_data,
    input  mem_data_in, mem_read_dn, mem_write_dn,
    output grant, done, rdata, mem_addr, mem_data_out, mem_read_q, mem_write_q,
    output is_bus_busy, err
  );

  modport master (
    output req_read, req_write, req_lock, req_addr, req_data,
    output mem_data_in, mem_read_dn, mem_write_dn,
    input  grant, done, rdata, mem_addr, mem_data_out, mem_read_q, mem_write_q,
    input  is_bus_busy, err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between N masters, with per-master bus lock.
// Optional watchdog on the memory done strobe is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("bus_arbiter: unsupported N or TIMEOUT");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic              locked_q, locked_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              dn_early_q, dn_early_d;

  logic [N-1:0]      pending;
  logic              dn_match;
  logic              sel_valid;
  logic [IdxW-1:0]   sel_idx;
  logic              release_lock;
  logic              timeout_hit;
  logic              timeout_q;

  assign pending  = bus.req_read | bus.req_write;
  assign dn_match = op_write_q ? bus.mem_write_dn : bus.mem_read_dn;

  // A locked owner is the only candidate; an idle owner that dropped its lock is released
  // and the round-robin search restarts just after it in the same cycle.
  always_comb begin
    int unsigned     base;
    logic [IdxW-1:0] cand;
    sel_valid    = 1'b0;
    sel_idx      = '0;
    release_lock = 1'b0;
    base         = 0;
    cand         = '0;
    if (locked_q) begin
      if (pending[owner_q]) begin
        sel_valid = 1'b1;
        sel_idx   = owner_q;
      end else if (!bus.req_lock[owner_q]) begin
        release_lock = 1'b1;
      end
    end
    if (!locked_q || release_lock) begin
      base = locked_q ? 32'(owner_q) : 32'(last_q);
      for (int unsigned j = 1; j <= N; j++) begin
        cand = IdxW'((base + j) % N);
        if (!sel_valid && pending[cand]) begin
          sel_valid = 1'b1;
          sel_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    last_d     = last_q;
    locked_d   = locked_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    dn_early_d = dn_early_q;
    unique case (state_q)
      StIdle: begin
        if (release_lock) begin
          grant_d  = '0;
          locked_d = 1'b0;
          last_d   = owner_q;
        end
        if (sel_valid) begin
          state_d          = StIssue;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          owner_d          = sel_idx;
          // Write wins when both are posted; the read stays pending for a later round.
          op_write_d       = bus.req_write[sel_idx];
          addr_d           = bus.req_addr[sel_idx*ADDR_W +: ADDR_W];
          data_d           = bus.req_data[sel_idx*DATA_W +: DATA_W];
          dn_early_d       = 1'b0;
        end
      end
      StIssue: begin
        state_d = StWait;
        if (dn_match) begin
          dn_early_d = 1'b1;
          if (!op_write_q) rdata_d = bus.mem_data_in;
        end
      end
      StWait: begin
        if (dn_early_q || dn_match) begin
          state_d = StResp;
          if (!dn_early_q && !op_write_q) rdata_d = bus.mem_data_in;
        end else if (timeout_hit) begin
          state_d = StResp;
          rdata_d = '0;
        end
      end
      StResp: begin
        state_d = StIdle;
        if (bus.req_lock[owner_q] && !timeout_q) begin
          locked_d = 1'b1;
        end else begin
          grant_d  = '0;
          locked_d = 1'b0;
          last_d   = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      owner_q    <= '0;
      last_q     <= IdxW'(N - 1);
      locked_q   <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      dn_early_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      locked_q   <= locked_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      dn_early_q <= dn_early_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_d;

  // Counter reads 0 during ISSUE, so the abort lands TIMEOUT cycles after ISSUE.
  assign timeout_hit = (state_q == StWait) && !dn_early_q && !dn_match &&
                       (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == StIdle) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (state_q == StIssue || state_q == StWait) begin
      cnt_d     = cnt_q + 16'd1;
      timeout_d = timeout_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.err = (state_q == StResp) && timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.grant        = grant_q;
  assign bus.is_bus_busy  = |grant_q;
  assign bus.done         = (state_q == StResp) ? grant_q : '0;
  assign bus.rdata        = rdata_q;
  assign bus.mem_addr     = (state_q == StIdle) ? '0 : addr_q;
  assign bus.mem_data_out = (state_q == StIdle) ? '0 : data_q;
  assign bus.mem_read_q   = (state_q == StIssue) && !op_write_q;
  assign bus.mem_write_q  = (state_q == StIssue) && op_write_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: scripted masters, a latency-programmable
// memory responder and a bus log compared against hand-computed expectations.
module tb_bus_arbiter;
  localparam int NM = 4;

  typedef struct packed {
    logic [1:0]  kind;  // 0 read, 1 write, 2 read+write posted together
    logic        lock;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } iss_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  logic clk;
  logic rst;
  int   cyc = 0;

  op_t         ops [NM][$];
  logic [NM-1:0] half_done;
  iss_t        iss_log[$];
  done_t       done_log[$];
  logic        err_seen = 1'b0;

  logic        mem_en = 1'b1;
  int          mem_lat = 1;
  logic [31:0] mem_rd_val = '0;
  logic        mem_is_rd;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter_if #(.N(NM), .ADDR_W(32), .DATA_W(32)) bus ();

  bus_arbiter #(.N(NM), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [1:0] kind, input logic lock,
                                input logic [31:0] addr, input logic [31:0] data);
    op_t o;
    o.kind = kind;
    o.lock = lock;
    o.addr = addr;
    o.data = data;
    return o;
  endfunction

  function automatic iss_t get_iss(input int k);
    iss_t r;
    r = '{cyc: -1, idx: 15, wr: 1'bx, addr: 'x, data: 'x};
    if (k < iss_log.size()) r = iss_log[k];
    return r;
  endfunction

  function automatic done_t get_done(input int k);
    done_t r;
    r = '{cyc: -1, idx: 15, rdata: 'x, err: 1'bx};
    if (k < done_log.size()) r = done_log[k];
    return r;
  endfunction

  function automatic int ops_left();
    int s = 0;
    for (int i = 0; i < NM; i++) s += ops[i].size();
    return s;
  endfunction

  function automatic logic [31:0] grant_seq(input int n);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) s = (s << 4) | 32'(get_iss(k).idx & 15);
    return s;
  endfunction

  task automatic drive_reqs();
    op_t cur;
    for (int i = 0; i < NM; i++) begin
      if (ops[i].size() == 0) begin
        half_done[i]     = 1'b0;
        bus.req_read[i]  = 1'b0;
        bus.req_write[i] = 1'b0;
        bus.req_lock[i]  = 1'b0;
      end else begin
        cur = ops[i][0];
        bus.req_read[i]  = (cur.kind == 2'd0) || (cur.kind == 2'd2);
        bus.req_write[i] = (cur.kind == 2'd1) || (cur.kind == 2'd2 && !half_done[i]);
        bus.req_lock[i]  = cur.lock;
        bus.req_addr[i*32 +: 32] = cur.addr;
        bus.req_data[i*32 +: 32] = cur.data;
      end
    end
  endtask

  // Masters plus bus monitor; a master drops (or replaces) its request in the done cycle.
  initial begin
    half_done    = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    drive_reqs();
    forever begin
      @(negedge clk);
      if (bus.err) err_seen = 1'b1;
      if (bus.mem_read_q || bus.mem_write_q) begin
        int g = 15;
        for (int i = 0; i < NM; i++) if (bus.grant[i]) g = i;
        iss_log.push_back('{cyc: cyc, idx: g, wr: bus.mem_write_q, addr: bus.mem_addr,
                           data: bus.mem_data_out});
      end
      for (int i = 0; i < NM; i++) begin
        if (bus.done[i]) begin
          done_log.push_back('{cyc: cyc, idx: i, rdata: bus.rdata, err: bus.err});
          if (ops[i].size() > 0) begin
            if (ops[i][0].kind == 2'd2 && !half_done[i]) begin
              half_done[i] = 1'b1;
            end else begin
              void'(ops[i].pop_front());
              half_done[i] = 1'b0;
            end
          end
        end
      end
      drive_reqs();
    end
  end

  // Memory: answers a request pulse with a one-cycle done mem_lat cycles later.
  initial begin
    bus.mem_read_dn  = 1'b0;
    bus.mem_write_dn = 1'b0;
    bus.mem_data_in  = '0;
    forever begin
      @(negedge clk);
      if (mem_en && rst && (bus.mem_read_q || bus.mem_write_q)) begin
        mem_is_rd = bus.mem_read_q;
        repeat (mem_lat) @(negedge clk);
        if (mem_is_rd) begin
          bus.mem_data_in = mem_rd_val;
          bus.mem_read_dn = 1'b1;
        end else begin
          bus.mem_write_dn = 1'b1;
        end
        @(negedge clk);
        bus.mem_read_dn  = 1'b0;
        bus.mem_write_dn = 1'b0;
      end
    end
  end

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while ((ops_left() != 0 || bus.is_bus_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_settled"}, 64'(n < budget), 64'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NM; i++) ops[i].delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_logs();
    iss_log.delete();
    done_log.delete();
  endtask

  initial begin
    int n;
    rst = 1'b0;
    @(negedge clk);
    check("rst_grant", 64'(bus.grant), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_busy", 64'(bus.is_bus_busy), 64'h0);
    check("rst_read_q", 64'(bus.mem_read_q), 64'h0);
    check("rst_write_q", 64'(bus.mem_write_q), 64'h0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    check("rst_err", 64'(bus.err), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single read by master 1, memory answers 3 cycles after read_q.
    mem_lat = 3;
    mem_rd_val = 32'hDEADBEEF;
    clear_logs();
    ops[1].push_back(mk_op(2'd0, 1'b0, 32'h10, 32'h0));
    wait_quiet("single", 100);
    check("single_issues", 64'(iss_log.size()), 64'd1);
    check("single_owner", 64'(get_iss(0).idx), 64'd1);
    check("single_is_read", 64'(get_iss(0).wr), 64'd0);
    check("single_addr", 64'(get_iss(0).addr), 64'h10);
    check("single_dones", 64'(done_log.size()), 64'd1);
    check("single_done_idx", 64'(get_done(0).idx), 64'd1);
    check("single_rdata", 64'(get_done(0).rdata), 64'hDEADBEEF);
    check("single_latency", 64'(get_done(0).cyc - get_iss(0).cyc), 64'd4);

    // All four masters request back to back from reset.
    apply_reset();
    mem_lat = 1;
    clear_logs();
    for (int i = 0; i < NM; i++) begin
      ops[i].push_back(mk_op(2'd0, 1'b0, 32'h100 + 32'(i), 32'h0));
      ops[i].push_back(mk_op(2'd0, 1'b0, 32'h200 + 32'(i), 32'h0));
    end
    wait_quiet("rr", 200);
    check("rr_issues", 64'(iss_log.size()), 64'd8);
    check("rr_order", 64'(grant_seq(8)), 64'h01230123);

    // Move the pointer to master 1, then master 2 holds the bus for read + write-back.
    clear_logs();
    ops[1].push_back(mk_op(2'd0, 1'b0, 32'h14, 32'h0));
    wait_quiet("lock_pre", 100);
    mem_rd_val = 32'hCAFE0001;
    clear_logs();
    ops[2].push_back(mk_op(2'd0, 1'b1, 32'h20, 32'h0));
    ops[2].push_back(mk_op(2'd1, 1'b1, 32'h20, 32'h44));
    ops[0].push_back(mk_op(2'd0, 1'b0, 32'h50, 32'h0));
    ops[3].push_back(mk_op(2'd0, 1'b0, 32'h60, 32'h0));
    wait_quiet("lock", 200);
    check("lock_order", 64'(grant_seq(4)), 64'h2230);
    check("lock_first_read", 64'(get_iss(0).wr), 64'd0);
    check("lock_wb_write", 64'(get_iss(1).wr), 64'd1);
    check("lock_wb_addr", 64'(get_iss(1).addr), 64'h20);
    check("lock_wb_data", 64'(get_iss(1).data), 64'h44);

    // Read and write posted together by master 0; memory answers in the ISSUE cycle.
    mem_lat = 0;
    mem_rd_val = 32'h12345678;
    clear_logs();
    ops[0].push_back(mk_op(2'd2, 1'b0, 32'h30, 32'h55));
    wait_quiet("both", 100);
    check("both_issues", 64'(iss_log.size()), 64'd2);
    check("both_first_write", 64'(get_iss(0).wr), 64'd1);
    check("both_second_read", 64'(get_iss(1).wr), 64'd0);
    check("both_dones", 64'(done_log.size()), 64'd2);
    check("both_write_keeps_rdata", 64'(get_done(0).rdata), 64'hCAFE0001);
    check("both_read_rdata", 64'(get_done(1).rdata), 64'h12345678);
    check("both_early_latency", 64'(get_done(1).cyc - get_iss(1).cyc), 64'd2);

    // Asynchronous reset while master 3 waits on a memory that never answers.
    mem_en = 1'b0;
    clear_logs();
    ops[3].push_back(mk_op(2'd0, 1'b0, 32'h70, 32'h0));
    n = 0;
    while (!bus.mem_read_q && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("arst_issue_seen", 64'(n < 20), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_grant", 64'(bus.grant), 64'h0);
    check("arst_busy", 64'(bus.is_bus_busy), 64'h0);
    check("arst_read_q", 64'(bus.mem_read_q), 64'h0);
    check("arst_write_q", 64'(bus.mem_write_q), 64'h0);
    ops[3].delete();
    repeat (3) @(negedge clk);
    check("arst_no_done", 64'(done_log.size()), 64'd0);
    rst = 1'b1;
    mem_en = 1'b1;
    mem_lat = 1;
    clear_logs();
    ops[2].push_back(mk_op(2'd0, 1'b0, 32'h80, 32'h0));
    ops[0].push_back(mk_op(2'd0, 1'b0, 32'h90, 32'h0));
    wait_quiet("arst_after", 100);
    check("arst_order", 64'(grant_seq(2)), 64'h02);

`ifdef BUS_ARB_TIMEOUT_EN
    mem_en = 1'b0;
    clear_logs();
    ops[1].push_back(mk_op(2'd0, 1'b0, 32'hA0, 32'h0));
    wait_quiet("tmo", 100);
    check("tmo_dones", 64'(done_log.size()), 64'd1);
    check("tmo_err", 64'(get_done(0).err), 64'd1);
    check("tmo_rdata", 64'(get_done(0).rdata), 64'h0);
    check("tmo_latency", 64'(get_done(0).cyc - get_iss(0).cyc), 64'd16);
    mem_en = 1'b1;
`else
    check("err_tied_low", 64'(err_seen), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sharing the single memory bus (addr/data, read_q/write_q, read_dn/write_dn) between N bus masters: the start managers and per-CPU execution units.
- Each master posts one read or write. The arbiter grants one master, issues the bus request, waits for the done strobe, returns read data and pulses a per-master done.
- A lock input lets a master keep the bus across back-to-back transactions, for example an IP read followed by an IP write-back.

Parameters:
- N, 4, number of requesters (2..8).
- ADDR_W, 32, address width (`ADDR_SIZE).
- DATA_W, 32, data width (`DATA_SIZE).
- TIMEOUT, 255, watchdog limit in cycles; used only with BUS_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req_read  in  N  per-master read request; held until that master's done
- req_write  in  N  per-master write request; held until that master's done
- req_lock  in  N  master keeps grant after its transaction completes
- req_addr  in  N*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- req_data  in  N*DATA_W  packed write data
- grant  out  N  one-hot current owner
- done  out  N  one-cycle completion pulse to owner
- rdata  out  DATA_W  read data, valid while done is high
- mem_addr  out  ADDR_W  bus address
- mem_data_out  out  DATA_W  bus write data
- mem_read_q  out  1  read request pulse
- mem_write_q  out  1  write request pulse
- mem_data_in  in  DATA_W  bus read data
- mem_read_dn  in  1  read complete
- mem_write_dn  in  1  write complete
- is_bus_busy  out  1  high from grant until release
- err  out  1  timeout pulse (0 when feature absent)

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; last-grant pointer = N-1, so master 0 has first priority. Reset mid-transaction aborts it with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - pending[i] = req_read[i] | req_write[i].
  - If a locked owner exists, only that owner is eligible. Otherwise search i = last+1 … last+N (mod N) and select the first pending master.
  - On selection, at the next edge: set grant one-hot; latch addr, data and op (write if req_write, else read); is_bus_busy=1; go to ISSUE.
- ISSUE:
  - Drive mem_addr/mem_data_out from the latched values.
  - mem_read_q or mem_write_q = 1 for exactly this one cycle.
  - Go to WAIT.
- WAIT:
  - mem_addr/mem_data_out held stable.
  - Matching strobe (mem_read_dn for read, mem_write_dn for write): capture mem_data_in into rdata on a read, then go to RESP.
  - Non-matching strobe is ignored.
  - A strobe sampled during ISSUE is accepted as if it arrived in WAIT.
- RESP:
  - done[owner]=1 for one cycle; rdata valid (write: rdata unchanged).
  - If req_lock[owner]=1: grant and is_bus_busy stay high, locked owner recorded.
  - Otherwise: grant=0, is_bus_busy=0, last=owner.
  - Go to IDLE.
- Latency:
  - Request sampled at edge k → mem_*_q high in cycle k+2.
  - dn sampled at edge m → done high in cycle m+1.
  - Minimum 4 cycles per transaction.
- Masters must drop their request in the cycle done is seen. A request still high one cycle after done is treated as a new request.
- req_read and req_write high together on one master: write is served first; the read stays pending.
- req_lock deasserted during a transaction: takes effect at RESP.
- Locked owner with no pending request in IDLE: if req_lock is still 1, hold grant and wait. If req_lock is 0, release without a transaction, set last=owner, and arbitrate in the same cycle.
- Pointer wraps modulo N. Fairness: no master waits more than N-1 other unlocked transactions.
- mem_addr/mem_data_out are 0 in IDLE when no grant is held.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter is cleared on ISSUE and increments in WAIT.
  - On reaching TIMEOUT with no matching dn: err pulses 1 cycle together with done[owner]; rdata=0; the lock is forcibly released; last=owner; go to IDLE.
- When undefined: WAIT is unbounded and err is tied to 0.

Test Plan:
- Single read: master 1 req_read, addr 0x10, memory returns 0xDEADBEEF with dn 3 cycles after read_q → grant=0010, one read_q pulse with mem_addr=0x10, done[1] one cycle, rdata=0xDEADBEEF.
- Round-robin: all 4 masters request continuously from reset → grant order 0,1,2,3,0, each done once per round.
- Lock: master 2 reads with lock=1, then writes 0x44 to 0x20, then drops lock; masters 0 and 3 also pending → no other grant between the read and write, then grant goes to 3.
- Simultaneous read+write on master 0 → write transaction first (write_q), then read; two done pulses.
- Async reset asserted in WAIT → grant, is_bus_busy and mem_*_q are 0 immediately; no done; next request goes to master 0 first.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT=16, no dn → err and done[owner] pulse 16 cycles after ISSUE; arbiter returns to IDLE.
